// File: rtl/pid_pkg.sv
// Shared definitions for the PID loop sequencer: FSM states and loop constants.
package pid_pkg;

    localparam int DEF_VAL_LENGTH = 32;
    localparam int MIN_PERIOD     = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_FB,
        S_CALC,
        S_WAIT_DP,
        S_CAPTURE
    } state_t;

endpackage

// File: rtl/pid_sequencer_sat_add.sv
// Signed add/subtract at W+1 bits, then clamped to [lo, hi].
// Purely combinational; no flow control.
module pid_sat_add #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    input  logic [W-1:0] lo,
    input  logic [W-1:0] hi,
    output logic [W-1:0] y
);

    logic signed [W:0] ax;
    logic signed [W:0] bx;
    logic signed [W:0] sum;
    logic signed [W:0] lox;
    logic signed [W:0] hix;

    always_comb begin
        ax  = {a[W-1], a};
        bx  = {b[W-1], b};
        lox = {lo[W-1], lo};
        hix = {hi[W-1], hi};
        sum = sub ? (ax - bx) : (ax + bx);
        y   = sum[W-1:0];
        if (sum < lox) begin
            y = lo;
        end else if (sum > hix) begin
            y = hi;
        end
    end

endmodule

// File: rtl/pid_sequencer.sv
// Sample-rate sequencer feeding the PID datapath: fetches feedback, computes err/int/dif, captures uk.
// Feedback accepted at edge N gives uk_valid after edge N+PIPE_LAT+3; waits indefinitely for fb_valid.
module pid_sequencer import pid_pkg::*; #(
    parameter int VAL_LENGTH = DEF_VAL_LENGTH,
    parameter int PIPE_LAT   = 1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  enable,
    input  logic                  int_clr,
    input  logic [31:0]           period,
    input  logic [VAL_LENGTH-1:0] setpoint,
    input  logic [VAL_LENGTH-1:0] int_max,
    input  logic [VAL_LENGTH-1:0] int_min,
    output logic                  fb_req,
    input  logic                  fb_valid,
    input  logic [VAL_LENGTH-1:0] feedback,
    output logic [VAL_LENGTH-1:0] err_val,
    output logic [VAL_LENGTH-1:0] int_val,
    output logic [VAL_LENGTH-1:0] dif_val,
    input  logic [VAL_LENGTH-1:0] dp_uk,
    output logic [VAL_LENGTH-1:0] uk_out,
    output logic                  uk_valid,
    output logic                  busy,
    output logic                  overrun
);

    localparam logic [VAL_LENGTH-1:0] SMAX = {1'b0, {(VAL_LENGTH-1){1'b1}}};
    localparam logic [VAL_LENGTH-1:0] SMIN = {1'b1, {(VAL_LENGTH-1){1'b0}}};
    localparam int                    DPW  = $clog2(PIPE_LAT + 2);
    localparam logic [DPW-1:0]        DP_LAST = DPW'(PIPE_LAT);
    localparam logic [31:0]           MIN_PER = 32'(MIN_PERIOD);

    state_t                  state;
    state_t                  state_nxt;
    logic [31:0]             tick_cnt;
    logic [31:0]             per_lim;
    logic [31:0]             per_eff;
    logic                    tick;
    logic [DPW-1:0]          dp_cnt;
    logic                    fb_req_nxt;
    logic                    uk_valid_nxt;
    logic                    ovr_set;
    logic [VAL_LENGTH-1:0]   fb_reg;
    logic [VAL_LENGTH-1:0]   int_reg;
    logic [VAL_LENGTH-1:0]   e_prev;
    logic [VAL_LENGTH-1:0]   int_base;
    logic [VAL_LENGTH-1:0]   eprev_base;
    logic [VAL_LENGTH-1:0]   e_calc;
    logic [VAL_LENGTH-1:0]   i_calc;
    logic [VAL_LENGTH-1:0]   d_calc;

    // The active limit is only reloaded at a wrap (or while stopped), so period writes land cleanly.
    assign per_eff = (period < MIN_PER) ? MIN_PER : period;
    assign tick    = enable && (tick_cnt == per_lim - 32'd1);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            tick_cnt <= '0;
            per_lim  <= MIN_PER;
        end else if (!enable || tick) begin
            tick_cnt <= '0;
            per_lim  <= per_eff;
        end else begin
            tick_cnt <= tick_cnt + 32'd1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (tick) state_nxt = S_WAIT_FB;
            S_WAIT_FB: if (fb_valid) state_nxt = S_CALC;
            S_CALC:    state_nxt = S_WAIT_DP;
            S_WAIT_DP: if (dp_cnt == DP_LAST) state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy         = (state != S_IDLE);
        fb_req_nxt   = (state == S_IDLE) && tick;
        uk_valid_nxt = (state == S_CAPTURE);
        ovr_set      = tick && (state != S_IDLE);
    end

    // A clear coinciding with CALC zeroes the history used by that very computation.
    assign int_base   = int_clr ? '0 : int_reg;
    assign eprev_base = int_clr ? '0 : e_prev;

    pid_sat_add #(.W(VAL_LENGTH)) u_err (
        .a   (setpoint),
        .b   (fb_reg),
        .sub (1'b1),
        .lo  (SMIN),
        .hi  (SMAX),
        .y   (e_calc)
    );

    pid_sat_add #(.W(VAL_LENGTH)) u_int (
        .a   (int_base),
        .b   (e_calc),
        .sub (1'b0),
        .lo  (int_min),
        .hi  (int_max),
        .y   (i_calc)
    );

    pid_sat_add #(.W(VAL_LENGTH)) u_dif (
        .a   (e_calc),
        .b   (eprev_base),
        .sub (1'b1),
        .lo  (SMIN),
        .hi  (SMAX),
        .y   (d_calc)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            fb_req   <= 1'b0;
            uk_valid <= 1'b0;
            overrun  <= 1'b0;
            dp_cnt   <= '0;
            fb_reg   <= '0;
            int_reg  <= '0;
            e_prev   <= '0;
            err_val  <= '0;
            int_val  <= '0;
            dif_val  <= '0;
            uk_out   <= '0;
        end else begin
            fb_req   <= fb_req_nxt;
            uk_valid <= uk_valid_nxt;

            if (!enable) begin
                overrun <= 1'b0;
            end else if (ovr_set) begin
                overrun <= 1'b1;
            end

            if (state == S_WAIT_DP) begin
                dp_cnt <= dp_cnt + DPW'(1);
            end else begin
                dp_cnt <= '0;
            end

            if (state == S_WAIT_FB && fb_valid) begin
                fb_reg <= feedback;
            end

            if (int_clr) begin
                int_reg <= '0;
                e_prev  <= '0;
            end

            if (state == S_CALC) begin
                err_val <= e_calc;
                int_val <= i_calc;
                dif_val <= d_calc;
                int_reg <= i_calc;
                e_prev  <= e_calc;
            end

            if (state == S_CAPTURE) begin
                uk_out <= dp_uk;
            end
        end
    end

endmodule

// File: tb/tb_pid_sequencer.sv
// Randomised scoreboard bench for pid_sequencer with a one-stage PID datapath stand-in (uk = e+i+d).
module tb_pid_sequencer;

    localparam int     VL     = 32;
    localparam int     PL     = 1;
    localparam longint SMAX_L = 64'sd2147483647;
    localparam longint SMIN_L = -64'sd2147483648;

    typedef struct {
        logic [31:0] e;
        logic [31:0] i;
        logic [31:0] d;
        logic [31:0] u;
        int          cyc;
    } exp_t;

    logic          sys_clk;
    logic          sys_rst;
    logic          enable;
    logic          int_clr;
    logic [31:0]   period;
    logic [VL-1:0] setpoint;
    logic [VL-1:0] int_max;
    logic [VL-1:0] int_min;
    logic          fb_req;
    logic          fb_valid;
    logic [VL-1:0] feedback;
    logic [VL-1:0] err_val;
    logic [VL-1:0] int_val;
    logic [VL-1:0] dif_val;
    logic [VL-1:0] dp_uk;
    logic [VL-1:0] uk_out;
    logic          uk_valid;
    logic          busy;
    logic          overrun;

    exp_t   sb[$];
    exp_t   mx;
    int     n_vec   = 0;
    int     n_err   = 0;
    int     cyc     = 0;
    longint m_int   = 0;
    longint m_eprev = 0;

    pid_sequencer #(.VAL_LENGTH(VL), .PIPE_LAT(PL)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .enable   (enable),
        .int_clr  (int_clr),
        .period   (period),
        .setpoint (setpoint),
        .int_max  (int_max),
        .int_min  (int_min),
        .fb_req   (fb_req),
        .fb_valid (fb_valid),
        .feedback (feedback),
        .err_val  (err_val),
        .int_val  (int_val),
        .dif_val  (dif_val),
        .dp_uk    (dp_uk),
        .uk_out   (uk_out),
        .uk_valid (uk_valid),
        .busy     (busy),
        .overrun  (overrun)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        cyc   <= cyc + 1;
        dp_uk <= err_val + int_val + dif_val;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic longint lim(input longint v, input longint lo, input longint hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic logic [31:0] rnd();
        logic [31:0] r;
        case ($urandom_range(0, 3))
            0:       r = 32'($urandom_range(0, 4000)) - 32'd2000;
            1:       r = $urandom();
            2:       r = 32'h7fffffff;
            default: r = 32'h80000000;
        endcase
        return r;
    endfunction

    // Reference: plain signed arithmetic on the loop equations, evaluated when feedback is handed over.
    task automatic model_push(input logic [31:0] fbv, input bit clr);
        longint e, i, d, bi, be;
        exp_t   x;
        e  = lim(longint'($signed(setpoint)) - longint'($signed(fbv)), SMIN_L, SMAX_L);
        bi = clr ? 0 : m_int;
        be = clr ? 0 : m_eprev;
        i  = lim(bi + e, longint'($signed(int_min)), longint'($signed(int_max)));
        d  = lim(e - be, SMIN_L, SMAX_L);
        m_int   = i;
        m_eprev = e;
        x.e   = e[31:0];
        x.i   = i[31:0];
        x.d   = d[31:0];
        x.u   = e[31:0] + i[31:0] + d[31:0];
        x.cyc = cyc + 1 + PL + 3;
        sb.push_back(x);
    endtask

    always @(negedge sys_clk) begin
        if (!sys_rst && uk_valid) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_uk_valid: got uk_valid=1 want no pending sample");
            end else begin
                mx = sb.pop_front();
                chk("err_val", err_val, mx.e);
                chk("int_val", int_val, mx.i);
                chk("dif_val", dif_val, mx.d);
                chk("uk_out", uk_out, mx.u);
                chk("uk_latency", 32'(cyc), 32'(mx.cyc));
            end
        end
    end

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge sys_clk);
            if (fb_req) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL req_timeout: got no fb_req in 100 cycles want fb_req");
        end
    endtask

    // Called in a cycle where the DUT is in WAIT_FB; returns in the first WAIT_DP cycle.
    task automatic respond(input logic [31:0] fbv, input int dly, input bit clr);
        repeat (dly) @(negedge sys_clk);
        feedback = fbv;
        fb_valid = 1'b1;
        model_push(fbv, clr);
        @(negedge sys_clk);
        fb_valid = 1'b0;
        int_clr  = clr;
        @(negedge sys_clk);
        int_clr  = 1'b0;
    endtask

    task automatic run_sample(input logic [31:0] fbv, input int dly, input bit clr);
        bit ok;
        wait_req(ok);
        if (ok) respond(fbv, dly, clr);
    endtask

    task automatic pulse_clr();
        @(negedge sys_clk);
        int_clr = 1'b1;
        @(negedge sys_clk);
        int_clr = 1'b0;
        m_int   = 0;
        m_eprev = 0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 50; k++) begin
            if (!busy) break;
            @(negedge sys_clk);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 100; k++) begin
            if (sb.size() == 0) break;
            @(negedge sys_clk);
        end
        chk("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_err"}, err_val, 32'd0);
        chk({name, "_int"}, int_val, 32'd0);
        chk({name, "_dif"}, dif_val, 32'd0);
        chk({name, "_uk"}, uk_out, 32'd0);
        chk({name, "_flags"}, {28'd0, fb_req, uk_valid, busy, overrun}, 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no completion want summary before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          plist[4];
        logic [31:0] a, b;

        sys_rst  = 1'b1;
        enable   = 1'b0;
        int_clr  = 1'b0;
        fb_valid = 1'b0;
        period   = 32'd10;
        setpoint = '0;
        int_max  = 32'd1000;
        int_min  = -32'sd1000;
        feedback = '0;
        repeat (3) @(negedge sys_clk);
        chk_all_zero("reset");
        sys_rst = 1'b0;
        @(negedge sys_clk);

        // Basic step
        setpoint = 32'd100;
        enable   = 1'b1;
        run_sample(32'd40, 1, 1'b0);
        run_sample(32'd40, 1, 1'b0);
        chk("overrun_clear", {31'd0, overrun}, 32'd0);

        // Anti-windup
        pulse_clr();
        setpoint = 32'd500;
        int_max  = 32'd1200;
        for (int k = 0; k < 4; k++) run_sample(32'd0, 1, 1'b0);
        run_sample(32'd900, 1, 1'b0);

        // Saturation at both ends
        int_max  = 32'h7fffffff;
        int_min  = 32'h80000000;
        setpoint = 32'h7fffffff;
        run_sample(-32'sd5, 1, 1'b0);
        setpoint = 32'h80000000;
        run_sample(32'd1, 1, 1'b0);

        // Clear landing on the CALC cycle: history 300/50, error 20
        pulse_clr();
        setpoint = 32'd100;
        int_max  = 32'd1000;
        int_min  = -32'sd1000;
        run_sample(-32'sd150, 1, 1'b0);
        run_sample(32'd50, 1, 1'b0);
        run_sample(32'd80, 1, 1'b1);

        // Overrun: late feedback with the shortest period
        drain();
        period = 32'd4;
        run_sample(32'd7, 6, 1'b0);
        chk("overrun_set", {31'd0, overrun}, 32'd1);
        wait_idle();
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge sys_clk);
            n++;
            if (fb_req) break;
        end
        chk("next_tick_after_idle", {31'd0, (n >= 1 && n <= 4)}, 32'd1);
        respond(32'd3, 1, 1'b0);

        // Period programming, including values below the minimum
        plist[0] = 0;
        plist[1] = 2;
        plist[2] = 7;
        plist[3] = $urandom_range(5, 15);
        for (int p = 0; p < 4; p++) begin
            wait_idle();
            enable = 1'b0;
            period = 32'(plist[p]);
            repeat (2) @(negedge sys_clk);
            if (p == 0) chk("overrun_cleared_by_enable", {31'd0, overrun}, 32'd0);
            enable = 1'b1;
            n = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge sys_clk);
                n++;
                if (fb_req) break;
            end
            chk("period_to_req", 32'(n), 32'((plist[p] < 4) ? 4 : plist[p]));
            if (p == 3) enable = 1'b0;
            respond(rnd(), 1, 1'b0);
        end

        // Enable dropped during WAIT_FB: exactly one capture, then silence
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge sys_clk);
            if (fb_req) n++;
        end
        chk("no_req_when_disabled", 32'(n), 32'd0);
        drain();

        // Reset while waiting on the datapath
        enable = 1'b1;
        period = 32'd5;
        run_sample(32'd11, 1, 1'b0);
        sys_rst = 1'b1;
        enable  = 1'b0;
        sb.delete();
        m_int   = 0;
        m_eprev = 0;
        @(negedge sys_clk);
        chk_all_zero("mid_reset");
        sys_rst = 1'b0;
        repeat (10) @(negedge sys_clk);

        // Randomised samples
        enable = 1'b1;
        for (int k = 0; k < 40; k++) begin
            period   = 32'($urandom_range(0, 12));
            setpoint = rnd();
            a = rnd();
            b = rnd();
            if ($signed(a) <= $signed(b)) begin
                int_min = a;
                int_max = b;
            end else begin
                int_min = b;
                int_max = a;
            end
            run_sample(rnd(), $urandom_range(0, 8), ($urandom_range(0, 7) == 0));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
